// File: rtl/controlador_vitais_if.sv
// Bundle between the state controller side and the vital-level tracker:
// time-base tick and state code in, level registers and death flag out.
interface controlador_vitais_if #(
  parameter int WIDTH = 4
);
  logic             tick;
  logic [3:0]       estado;
  logic [WIDTH-1:0] saciedade;
  logic [WIDTH-1:0] energia;
  logic [WIDTH-1:0] alegria;
  logic             morreu;

  modport master (
    output tick,
    output estado,
    input  saciedade,
    input  energia,
    input  alegria,
    input  morreu
  );

  modport slave (
    input  tick,
    input  estado,
    output saciedade,
    output energia,
    output alegria,
    output morreu
  );
endinterface

// File: rtl/controlador_vitais.sv
// Vital-level tracker for the pet: saturating saciedade/energia/alegria
// counters updated on time-base ticks, with a sticky death flag that
// freezes everything until reset.
module controlador_vitais #(
  parameter int WIDTH       = 4,
  parameter int DECAY_TICKS = 4
) (
  input  logic               clk,
  input  logic               rst,
  controlador_vitais_if.slave bus
);

  localparam int               CW       = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  localparam logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}};
  localparam logic [CW-1:0]    CNT_LAST = CW'(DECAY_TICKS - 1);

  localparam logic [3:0] ST_DORMINDO   = 4'b0001;
  localparam logic [3:0] ST_COMENDO    = 4'b0010;
  localparam logic [3:0] ST_DANDO_AULA = 4'b0100;
  localparam logic [3:0] ST_MORTO      = 4'b1000;

  logic [WIDTH-1:0] saciedade_q, saciedade_d;
  logic [WIDTH-1:0] energia_q, energia_d;
  logic [WIDTH-1:0] alegria_q, alegria_d;
  logic             morreu_q, morreu_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             frozen_s;
  logic             advance_s;
  logic             decay_s;
  logic [1:0]       dec1_s;

  // Increment that sticks at MAX instead of wrapping.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    if (v == MAX) begin
      sat_inc = MAX;
    end else begin
      sat_inc = v + WIDTH'(1);
    end
  endfunction

  // Decrement by 0..3 that sticks at zero instead of wrapping.
  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v,
                                               input logic [1:0]       amt);
    if ({1'b0, v} > (WIDTH+1)'(amt)) begin
      sat_dec = v - WIDTH'(amt);
    end else begin
      sat_dec = {WIDTH{1'b0}};
    end
  endfunction

  // Next-state computation for levels, decay counter and death flag.
  always_comb begin
    saciedade_d = saciedade_q;
    energia_d   = energia_q;
    alegria_d   = alegria_q;
    cnt_d       = cnt_q;

    // A dead pet or the MORTO state holds every level and the counter.
    frozen_s  = morreu_q | (bus.estado == ST_MORTO);
    advance_s = bus.tick & ~frozen_s;
    decay_s   = advance_s & (cnt_q == CNT_LAST);
    dec1_s    = decay_s ? 2'd1 : 2'd0;

    // Death looks at the registered levels, so it trails a zero by one edge.
    morreu_d = morreu_q | (saciedade_q == {WIDTH{1'b0}}) | (energia_q == {WIDTH{1'b0}});

    if (advance_s) begin
      if (decay_s) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end

      case (bus.estado)
        ST_DORMINDO: begin
          energia_d   = sat_inc(energia_q);
          saciedade_d = sat_dec(saciedade_q, dec1_s);
          alegria_d   = sat_dec(alegria_q, dec1_s);
        end
        ST_COMENDO: begin
          saciedade_d = sat_inc(saciedade_q);
          energia_d   = sat_dec(energia_q, dec1_s);
          alegria_d   = sat_dec(alegria_q, dec1_s);
        end
        ST_DANDO_AULA: begin
          alegria_d   = sat_inc(alegria_q);
          energia_d   = sat_dec(energia_q, 2'd1 + dec1_s);
          saciedade_d = sat_dec(saciedade_q, dec1_s);
        end
        default: begin
          // IDLE and every unrecognised code share the plain decay.
          saciedade_d = sat_dec(saciedade_q, dec1_s);
          energia_d   = sat_dec(energia_q, dec1_s);
          alegria_d   = sat_dec(alegria_q, dec1_s);
        end
      endcase
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset to full levels and alive.
  always_ff @(posedge clk) begin
    if (rst) begin
      saciedade_q <= MAX;
      energia_q   <= MAX;
      alegria_q   <= MAX;
      morreu_q    <= 1'b0;
      cnt_q       <= {CW{1'b0}};
    end else begin
      saciedade_q <= saciedade_d;
      energia_q   <= energia_d;
      alegria_q   <= alegria_d;
      morreu_q    <= morreu_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.saciedade = saciedade_q;
  assign bus.energia   = energia_q;
  assign bus.alegria   = alegria_q;
  assign bus.morreu    = morreu_q;

endmodule

// File: tb/tb_controlador_vitais.sv
// Directed bench for controlador_vitais with a behavioural reference model
// feeding a scoreboard queue, plus literal spot checks of key values.
module tb_controlador_vitais;

  localparam int DT = 4;

  logic clk;
  logic rst;

  controlador_vitais_if #(.WIDTH(4)) vif ();

  controlador_vitais #(.WIDTH(4), .DECAY_TICKS(DT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   sac;
    int   ene;
    int   ale;
    logic dead;
  } exp_t;

  exp_t q_exp[$];

  int errors = 0;
  int checks = 0;

  // reference model state
  int   m_sac, m_ene, m_ale, m_cnt;
  logic m_dead;

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > 15) return 15;
    return v;
  endfunction

  task automatic model_step(input logic r, input logic t, input logic [3:0] e);
    logic n_dead;
    bit   ev;
    int   ds, de, da;
    if (r) begin
      m_sac = 15; m_ene = 15; m_ale = 15; m_cnt = 0; m_dead = 1'b0;
    end else begin
      n_dead = m_dead || (m_sac == 0) || (m_ene == 0);
      if (t && !m_dead && e != 4'b1000) begin
        ev = (m_cnt == DT - 1);
        m_cnt = ev ? 0 : m_cnt + 1;
        ds = 0; de = 0; da = 0;
        if (e == 4'b0001) begin
          de = 1;  ds = ev ? -1 : 0; da = ev ? -1 : 0;
        end else if (e == 4'b0010) begin
          ds = 1;  de = ev ? -1 : 0; da = ev ? -1 : 0;
        end else if (e == 4'b0100) begin
          da = 1;  de = ev ? -2 : -1; ds = ev ? -1 : 0;
        end else begin
          ds = ev ? -1 : 0; de = ds; da = ds;
        end
        m_sac = clamp(m_sac + ds);
        m_ene = clamp(m_ene + de);
        m_ale = clamp(m_ale + da);
      end
      m_dead = n_dead;
    end
  endtask

  // One clock: drive inputs, push the model's prediction, compare after the edge.
  task automatic cycle(input logic r, input logic t, input logic [3:0] e, input string tag);
    exp_t x, got;
    rst        = r;
    vif.tick   = t;
    vif.estado = e;
    model_step(r, t, e);
    x.sac = m_sac; x.ene = m_ene; x.ale = m_ale; x.dead = m_dead;
    q_exp.push_back(x);
    @(posedge clk);
    #1;
    got.sac  = int'(vif.saciedade);
    got.ene  = int'(vif.energia);
    got.ale  = int'(vif.alegria);
    got.dead = vif.morreu;
    checks++;
    if (q_exp.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      x = q_exp.pop_front();
      assert (got.sac === x.sac && got.ene === x.ene && got.ale === x.ale && got.dead === x.dead)
      else begin
        errors++;
        $error("FAIL %s: observed s=%0d e=%0d a=%0d m=%0b expected s=%0d e=%0d a=%0d m=%0b",
               tag, got.sac, got.ene, got.ale, got.dead, x.sac, x.ene, x.ale, x.dead);
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic ticks(input int n, input logic [3:0] e, input string tag);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b1, e, tag);
      cycle(1'b0, 1'b0, e, tag);
    end
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b1, 4'b0000, "reset");
    cycle(1'b0, 1'b0, 4'b0000, "post_reset");
  endtask

  task automatic lv(input string tag, input int s, input int e, input int a, input int m);
    chk({tag, "_sac"}, int'(vif.saciedade), s);
    chk({tag, "_ene"}, int'(vif.energia), e);
    chk({tag, "_ale"}, int'(vif.alegria), a);
    chk({tag, "_morreu"}, int'(vif.morreu), m);
  endtask

  initial begin
    rst = 1'b1; vif.tick = 1'b0; vif.estado = 4'b0000;
    m_sac = 0; m_ene = 0; m_ale = 0; m_cnt = 0; m_dead = 1'b0;

    // 1: reset with tick high applies no decrement
    cycle(1'b1, 1'b1, 4'b0000, "reset_tick");
    lv("t1_reset", 15, 15, 15, 0);
    cycle(1'b0, 1'b0, 4'b0000, "idle");

    // 2: IDLE decay every 4th tick
    ticks(3, 4'b0000, "idle_decay");
    lv("t2_after3", 15, 15, 15, 0);
    ticks(1, 4'b0000, "idle_decay");
    lv("t2_after4", 14, 14, 14, 0);
    ticks(4, 4'b0000, "idle_decay");
    lv("t2_after8", 13, 13, 13, 0);

    // 3: COMENDO recovery and saturation from 14/14/14
    do_reset();
    ticks(4, 4'b0000, "idle_pre");
    ticks(1, 4'b0010, "comendo");
    chk("t3_sac_recover", int'(vif.saciedade), 15);
    ticks(4, 4'b0010, "comendo");
    lv("t3_comendo", 15, 13, 13, 0);

    // 4: DANDO_AULA
    do_reset();
    ticks(4, 4'b0100, "aula");
    lv("t4_aula", 14, 10, 15, 0);

    // 5: death after 60 IDLE ticks
    do_reset();
    ticks(59, 4'b0000, "idle_death");
    cycle(1'b0, 1'b1, 4'b0000, "tick60");
    lv("t5_tick60", 0, 0, 0, 0);
    cycle(1'b0, 1'b0, 4'b0000, "after60");
    chk("t5_morreu_rise", int'(vif.morreu), 1);
    ticks(2, 4'b0001, "dead_dorm");
    ticks(2, 4'b0010, "dead_com");
    ticks(2, 4'b0100, "dead_aula");
    lv("t5_frozen", 0, 0, 0, 1);
    cycle(1'b1, 1'b0, 4'b0100, "rst_dead");
    lv("t5_revive", 15, 15, 15, 0);
    cycle(1'b0, 1'b0, 4'b0000, "idle");

    // 6: MORTO freezes, unknown code acts as IDLE
    ticks(8, 4'b1000, "morto");
    lv("t6_morto", 15, 15, 15, 0);
    ticks(3, 4'b0011, "unknown");
    chk("t6_unk3_sac", int'(vif.saciedade), 15);
    ticks(1, 4'b0011, "unknown");
    lv("t6_unk4", 14, 14, 14, 0);

    // MORTO holds the decay counter mid-count
    ticks(1, 4'b0000, "cnt1");
    ticks(3, 4'b1000, "morto_mid");
    ticks(2, 4'b0000, "cnt3");
    chk("t6_cnt_held_sac", int'(vif.saciedade), 14);
    ticks(1, 4'b0000, "cnt_wrap");
    chk("t6_cnt_event_sac", int'(vif.saciedade), 13);

    // DANDO_AULA -2 from 1 saturates at 0
    do_reset();
    ticks(59, 4'b0010, "com_drain");
    lv("sat_pre", 15, 1, 1, 0);
    ticks(1, 4'b0100, "aula_sat");
    chk("sat_ene_zero", int'(vif.energia), 0);
    chk("sat_sac", int'(vif.saciedade), 14);
    chk("sat_ale", int'(vif.alegria), 2);
    chk("sat_morreu", int'(vif.morreu), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
